// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundle of the request and response signals of alu_share_arbiter.
//
//   Handshake rule (both channels): a beat transfers on a rising clk edge
//   where valid && ready are both 1. A requester keeps its payload
//   (a, b, op) stable while its valid is 1 and no transfer has happened.
//   A requester may drop valid at any time. The response payload
//   (id, res, zero) stays stable while rsp_valid is 1 and rsp_ready is 0.
//
//   Signals:
//     req_valid [NUM_REQ]     requester -> arbiter
//     req_ready [NUM_REQ]     arbiter -> requester, at most one bit set
//     req_a/req_b [NUM_REQ*32] packed operands, requester i at [32i +: 32]
//     req_op    [NUM_REQ*3]   packed opcodes, requester i at [3i +: 3]
//     rsp_valid               response slot full
//     rsp_ready               consumer accepts the response
//     rsp_id    [ID_W]        owner of the response
//     rsp_res   [32]          ALU result
//     rsp_zero                1 when rsp_res == 0
//
//   Modports: slave  = the arbiter side
//             master = the requester / consumer side
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*3-1:0]  req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_res;
  logic                  rsp_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_zero
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one arith_logic_unit between NUM_REQ requesters (2..4). One
//   request is granted per cycle, round-robin from pointer ptr, and its
//   result is captured in a single registered response slot returned with
//   the owner's index.
//
//   Build option:
//     ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                         no round-robin pointer.
//                            undefined -> round-robin (default).
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        alu_share_arbiter_if.slave (request and response channels)
//     dbg_state  slot state: 0 = EMPTY, 1 = FULL
//     dbg_ptr    current round-robin pointer (always 0 in fixed priority)
//
//   Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//            101 SLL, 110 SRL (shift = b[4:0]), 111 SLT (unsigned).
//   ID_W must be at least log2(NUM_REQ).
// ---------------------------------------------------------------------------

module arith_logic_unit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] res,
  output logic        zero
);
  always_comb begin
    res = '0;
    case (op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = a ^ b;
      3'b101:  res = a << b[4:0];
      3'b110:  res = a >> b[4:0];
      default: res = {31'd0, (a < b)};
    endcase
  end

  assign zero = (res == 32'd0);
endmodule

module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output logic                 dbg_state,
  output logic [ID_W-1:0]      dbg_ptr
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rsp_id_q;
  logic [31:0]        rsp_res_q;
  logic               rsp_zero_q;

  logic [PTR_W-1:0]   start;
  logic               slot_free;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               xfer;

  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [2:0]         alu_op;
  logic [31:0]        alu_res;
  logic               alu_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Search always begins at requester 0, so lower indices win.
  assign start = '0;
`else
  logic [PTR_W-1:0] ptr;
  assign start = ptr;
`endif

  // A new result may enter whenever the slot is empty or is being drained
  // this very cycle; this makes rsp_ready a combinational input to req_ready.
  assign slot_free = (state == EMPTY) || bus.rsp_ready;

  // Circular search from start; the first valid requester wins.
  always_comb begin
    logic             found;
    int               idx;
    logic [PTR_W-1:0] idx_w;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_w   = '0;
    if (slot_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(start) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_w = PTR_W'(idx);
        if (!found && bus.req_valid[idx_w]) begin
          found        = 1'b1;
          grant[idx_w] = 1'b1;
          gnt_idx      = idx_w;
        end
      end
    end
  end

  assign xfer          = |grant;
  assign bus.req_ready = grant;

  // Operand mux: the granted requester (or requester 0 when idle) feeds the ALU.
  always_comb begin
    int sel;
    sel    = int'(gnt_idx);
    alu_a  = bus.req_a[32*sel +: 32];
    alu_b  = bus.req_b[32*sel +: 32];
    alu_op = bus.req_op[3*sel +: 3];
  end

  arith_logic_unit u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .res  (alu_res),
    .zero (alu_zero)
  );

  // Slot FSM: a transfer always (re)loads the slot, a drain without a
  // transfer empties it, anything else holds the contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_id_q   <= '0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      if (xfer) begin
        state      <= FULL;
        rsp_id_q   <= ID_W'(gnt_idx);
        rsp_res_q  <= alu_res;
        rsp_zero_q <= alu_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr        <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
`endif
      end else if (state == FULL && bus.rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_zero  = rsp_zero_q;

  assign dbg_state = state;
  assign dbg_ptr   = ID_W'(start);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter with NUM_REQ = 2. Inputs change 1 ns after
//   a rising edge; outputs are sampled on the falling edge. Responses are
//   matched against an expected queue of {id, zero, res}.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 33;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic dbg_state;
  logic [ID_W-1:0] dbg_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rsp(input int id, input logic [31:0] res);
    return {ID_W'(id), (res == 32'd0), res};
  endfunction

  // Pop one expected entry each time the consumer takes a response.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h expected none", {bus.rsp_id, bus.rsp_zero, bus.rsp_res});
      end else begin
        check("rsp", 64'({bus.rsp_id, bus.rsp_zero, bus.rsp_res}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
    bus.req_op[3*i +: 3]   = op;
  endtask

  task automatic clear_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [NUM_REQ-1:0] exp_gnt;
    int g;

    vecs[0]  = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0000};
    vecs[1]  = '{1, 32'h0000_0005, 32'h0000_0003, 3'b001, 32'h0000_0002};
    vecs[2]  = '{0, 32'h0000_0000, 32'h0000_0001, 3'b001, 32'hFFFF_FFFF};
    vecs[3]  = '{1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000};
    vecs[4]  = '{0, 32'h1234_0000, 32'h0000_5678, 3'b011, 32'h1234_5678};
    vecs[5]  = '{1, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 3'b100, 32'h5555_5555};
    vecs[6]  = '{0, 32'h0000_0001, 32'h0000_0021, 3'b101, 32'h0000_0002};
    vecs[7]  = '{1, 32'h8000_0000, 32'h0000_001F, 3'b110, 32'h0000_0001};
    vecs[8]  = '{0, 32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0000};
    vecs[9]  = '{1, 32'h0000_0003, 32'h0000_0007, 3'b111, 32'h0000_0001};
    vecs[10] = '{0, 32'h0000_0005, 32'h0000_0005, 3'b100, 32'h0000_0000};
    vecs[11] = '{1, 32'hFFFF_FFFF, 32'h0000_0004, 3'b101, 32'hFFFF_FFF0};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("reset_rsp_res",   64'(bus.rsp_res),   64'd0);
    check("reset_rsp_zero",  64'(bus.rsp_zero),  64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);

    // Table: one requester at a time, response drained immediately.
    for (int v = 0; v < 12; v++) begin
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      drive_req(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].op);
      @(negedge clk);
      exp_gnt = NUM_REQ'(1) << vecs[v].req;
      check($sformatf("vec%0d_req_ready", v), 64'(bus.req_ready), 64'(exp_gnt));
      exp_q.push_back(exp_rsp(vecs[v].req, vecs[v].exp_res));
      @(posedge clk);
      #1 clear_req(vecs[v].req);
      @(negedge clk);
      check($sformatf("vec%0d_latency", v), 64'(bus.rsp_valid), 64'd1);
    end

    // Round-robin: both requesters held for four cycles (ptr is 0 here).
    @(posedge clk);
    #1;
    drive_req(0, 32'd5, 32'd3, 3'b001);
    drive_req(1, 32'd1, 32'h21, 3'b101);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = c % 2;
`endif
      check($sformatf("rr%0d_req_ready", c), 64'(bus.req_ready), 64'(NUM_REQ'(1) << g));
      exp_q.push_back(exp_rsp(g, 32'd2));
      @(posedge clk);
      #1;
    end
    clear_req(0);
    clear_req(1);
    @(posedge clk);
    #1;

    // Back-pressure: SLT 3<7 held in the slot while a second request waits.
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'd3, 32'd7, 3'b111);
    @(negedge clk);
    check("bp_first_grant", 64'(bus.req_ready), 64'b01);
    exp_q.push_back(exp_rsp(0, 32'd1));
    @(posedge clk);
    #1;
    clear_req(0);
    drive_req(1, 32'd10, 32'd20, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_req_ready", c), 64'(bus.req_ready), 64'd0);
      check($sformatf("bp%0d_hold", c),
            64'({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_res}),
            64'({1'b1, exp_rsp(0, 32'd1)}));
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_grant", 64'(bus.req_ready), 64'b10);
    exp_q.push_back(exp_rsp(1, 32'd30));
    @(posedge clk);
    #1 clear_req(1);
    @(negedge clk);
    check("bp_reload_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-stall: load requester 0 (ptr -> 1) and hold it.
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'h0000_00F0, 32'h0000_000F, 3'b011);
    @(posedge clk);
    #1 clear_req(0);
    @(negedge clk);
    check("stall_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          64'({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_res}), 64'd0);
    check("rst_mid_req_ready", 64'(bus.req_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drive_req(0, 32'd7, 32'd8, 3'b000);
    drive_req(1, 32'd1, 32'd1, 3'b000);
    @(negedge clk);
    check("post_rst_grant", 64'(bus.req_ready), 64'b01);
    exp_q.push_back(exp_rsp(0, 32'd15));
    @(posedge clk);
    #1;
    clear_req(0);
    clear_req(1);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
